// File: rtl/sklansky_bist_pkg.sv
// Shared definitions for the Sklansky adder self-test engine:
// FSM state encoding and the vector-space size helper.
package sklansky_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Number of {cin,b,a} combinations for an n-bit adder.
    function automatic int vec_space(input int n);
        return 1 << (2 * n + 1);
    endfunction

endpackage

// File: rtl/Sklansky_par.sv
// Parallel-prefix (Sklansky) adder: log2(N) levels of generate/propagate
// combining, with the carry-in folded in after the prefix tree.
module Sklansky_par #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int LEVELS = $clog2(N);

    logic [N-1:0] p0;
    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;
    int           j;

    always_comb begin
        p0 = a ^ b;
        g  = a & b;
        p  = p0;
        j  = 0;
        // Bit j never has bit l set, so it is not rewritten within the same level.
        for (int l = 0; l < LEVELS; l++) begin
            for (int i = 0; i < N; i++) begin
                if (i[l]) begin
                    j    = ((i >> l) << l) - 1;
                    g[i] = g[i] | (p[i] & g[j]);
                    p[i] = p[i] & p[j];
                end
            end
        end
        c[0] = cin;
        for (int i = 0; i < N; i++) begin
            c[i+1] = g[i] | (p[i] & cin);
        end
    end

    assign sum  = p0 ^ c[N-1:0];
    assign cout = c[N];

endmodule

// File: rtl/sklansky_bist.sv
// Self-test engine: sweeps every {cin,b,a} through a Sklansky_par instance
// and checks {cout,sum} against a behavioural sum, recording the first failure.
module sklansky_bist
    import sklansky_bist_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           inj_en,
    input  logic [2*N:0]   inj_vec,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [2*N+1:0] err_count,
    output logic           fail_seen,
    output logic [2*N:0]   fail_vec
);

    localparam int          VW       = 2 * N + 1;
    localparam int          M        = vec_space(N);
    localparam logic [VW-1:0] VEC_LAST = VW'(M - 1);

    state_t        state;
    state_t        state_next;
    logic [VW-1:0] vec;
    logic [VW-1:0] op_q;
    logic          op_v;

    logic [N-1:0]  op_a;
    logic [N-1:0]  op_b;
    logic          op_cin;
    logic [N-1:0]  sum;
    logic          cout;
    logic [N:0]    golden;
    logic [N:0]    observed;
    logic          inj_hit;
    logic          mismatch;
    logic          launch;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (vec == VEC_LAST) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    assign launch = ((state == IDLE) || (state == DONE)) && start;
    assign busy   = (state == RUN) || (state == DRAIN);
    assign done   = (state == DONE);
    assign pass   = done && (err_count == '0);

    assign op_a   = op_q[N-1:0];
    assign op_b   = op_q[2*N-1:N];
    assign op_cin = op_q[2*N];

    Sklansky_par #(.N(N)) u_adder (
        .a    (op_a),
        .b    (op_b),
        .cin  (op_cin),
        .sum  (sum),
        .cout (cout)
    );

    assign golden   = {1'b0, op_a} + {1'b0, op_b} + {{N{1'b0}}, op_cin};
    assign inj_hit  = inj_en && (op_q == inj_vec);
    assign observed = {cout, sum} ^ {{N{1'b0}}, inj_hit};
    assign mismatch = (observed != golden);

    always_ff @(posedge clk) begin
        if (rst) begin
            vec       <= '0;
            op_q      <= '0;
            op_v      <= 1'b0;
            err_count <= '0;
            fail_seen <= 1'b0;
            fail_vec  <= '0;
        end else if (launch) begin
            vec       <= '0;
            op_v      <= 1'b0;
            err_count <= '0;
            fail_seen <= 1'b0;
            fail_vec  <= '0;
        end else begin
            // vec wraps to 0 on the last RUN edge; the FSM leaves RUN there.
            if (state == RUN) begin
                op_q <= vec;
                op_v <= 1'b1;
                vec  <= vec + 1'b1;
            end else begin
                op_v <= 1'b0;
            end
            if (op_v && mismatch) begin
                err_count <= err_count + 1'b1;
                if (!fail_seen) begin
                    fail_seen <= 1'b1;
                    fail_vec  <= op_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_sklansky_bist.sv
// Directed bench for sklansky_bist (N=4, 512 vectors): clean sweeps,
// injected faults, held start, mid-sweep reset and restart after failure.
module tb_sklansky_bist;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         inj_en;
    logic [2*N:0] inj_vec;
    logic         busy;
    logic         done;
    logic         pass;
    logic [2*N+1:0] err_count;
    logic         fail_seen;
    logic [2*N:0] fail_vec;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sklansky_bist #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .inj_en    (inj_en),
        .inj_vec   (inj_vec),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .fail_seen (fail_seen),
        .fail_vec  (fail_vec)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues the start edge (edge 0) and waits, bounded, for done.
    // edges counts edges after edge 0; busy_edges counts cycles with busy=1.
    task automatic run_sweep(input logic hold_start, output int edges, output int busy_edges);
        start = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        busy_edges = busy ? 1 : 0;
        edges = 0;
        while (!done && edges < 2000) begin
            tick();
            edges++;
            if (busy) busy_edges++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; inj_en = 1'b0; inj_vec = '0;
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if ({busy, done, pass, fail_seen} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got busy/done/pass/fail_seen=%b expected 0000", {busy, done, pass, fail_seen});
        end
        checks++;
        if (err_count !== 10'd0) begin
            errors++;
            $display("FAIL reset_err_count: got %0d expected 0", err_count);
        end
        checks++;
        if (fail_vec !== 9'h000) begin
            errors++;
            $display("FAIL reset_fail_vec: got %h expected 000", fail_vec);
        end
    endtask

    task automatic test_clean_pass();
        int edges, busy_edges;
        inj_en = 1'b0;
        run_sweep(1'b0, edges, busy_edges);
        checks++;
        if (edges !== 513) begin
            errors++;
            $display("FAIL clean_done_edge: got %0d expected 513", edges);
        end
        checks++;
        if (busy_edges !== 513) begin
            errors++;
            $display("FAIL clean_busy_cycles: got %0d expected 513", busy_edges);
        end
        checks++;
        if ({done, pass, fail_seen} !== 3'b110) begin
            errors++;
            $display("FAIL clean_flags: got done/pass/fail_seen=%b expected 110", {done, pass, fail_seen});
        end
        checks++;
        if (err_count !== 10'd0 || fail_vec !== 9'h000) begin
            errors++;
            $display("FAIL clean_result: got err_count=%0d fail_vec=%h expected 0/000", err_count, fail_vec);
        end
    endtask

    task automatic test_inject(input string name, input logic [2*N:0] vec_in);
        int edges, busy_edges;
        inj_en = 1'b1;
        inj_vec = vec_in;
        run_sweep(1'b0, edges, busy_edges);
        checks++;
        if (edges !== 513 || done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: got edges=%0d done=%b expected 513/1", name, edges, done);
        end
        checks++;
        if (err_count !== 10'd1) begin
            errors++;
            $display("FAIL %s_err_count: got %0d expected 1", name, err_count);
        end
        checks++;
        if (fail_vec !== vec_in) begin
            errors++;
            $display("FAIL %s_fail_vec: got %h expected %h", name, fail_vec, vec_in);
        end
        checks++;
        if ({pass, fail_seen} !== 2'b01) begin
            errors++;
            $display("FAIL %s_pass_seen: got pass/fail_seen=%b expected 01", name, {pass, fail_seen});
        end
    endtask

    task automatic test_restart_after_fail();
        int edges;
        inj_en = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({done, busy} !== 2'b01 || err_count !== 10'd0 || fail_seen !== 1'b0) begin
            errors++;
            $display("FAIL restart_clear: got done=%b busy=%b err_count=%0d fail_seen=%b expected 0/1/0/0",
                     done, busy, err_count, fail_seen);
        end
        edges = 0;
        while (!done && edges < 2000) begin
            tick();
            edges++;
        end
        checks++;
        if (edges !== 513 || pass !== 1'b1 || err_count !== 10'd0) begin
            errors++;
            $display("FAIL restart_pass: got edges=%0d pass=%b err_count=%0d expected 513/1/0", edges, pass, err_count);
        end
    endtask

    task automatic test_held_start();
        int edges, busy_edges;
        inj_en = 1'b1;
        inj_vec = 9'h0A5;
        run_sweep(1'b1, edges, busy_edges);
        checks++;
        if (edges !== 513 || busy_edges !== 513) begin
            errors++;
            $display("FAIL held_single_sweep: got edges=%0d busy=%0d expected 513/513", edges, busy_edges);
        end
        checks++;
        if (err_count !== 10'd1 || fail_vec !== 9'h0A5) begin
            errors++;
            $display("FAIL held_result: got err_count=%0d fail_vec=%h expected 1/0a5", err_count, fail_vec);
        end
        tick();
        start = 1'b0;
        inj_en = 1'b0;
        checks++;
        if ({done, busy} !== 2'b01 || err_count !== 10'd0) begin
            errors++;
            $display("FAIL held_restart: got done=%b busy=%b err_count=%0d expected 0/1/0", done, busy, err_count);
        end
        edges = 0;
        while (!done && edges < 2000) begin
            tick();
            edges++;
        end
        checks++;
        if (edges !== 513 || pass !== 1'b1) begin
            errors++;
            $display("FAIL held_second_pass: got edges=%0d pass=%b expected 513/1", edges, pass);
        end
    endtask

    task automatic test_reset_mid();
        int edges, busy_edges;
        inj_en = 1'b1;
        inj_vec = 9'h010;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (99) tick();
        checks++;
        if (busy !== 1'b1 || err_count !== 10'd1 || fail_vec !== 9'h010) begin
            errors++;
            $display("FAIL midrun_partial: got busy=%b err_count=%0d fail_vec=%h expected 1/1/010", busy, err_count, fail_vec);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        inj_en = 1'b0;
        checks++;
        if ({busy, done, pass, fail_seen} !== 4'b0000 || err_count !== 10'd0 || fail_vec !== 9'h000) begin
            errors++;
            $display("FAIL midrun_reset: got busy/done/pass/seen=%b err_count=%0d fail_vec=%h expected 0000/0/000",
                     {busy, done, pass, fail_seen}, err_count, fail_vec);
        end
        run_sweep(1'b0, edges, busy_edges);
        checks++;
        if (edges !== 513 || pass !== 1'b1 || err_count !== 10'd0) begin
            errors++;
            $display("FAIL midrun_fresh: got edges=%0d pass=%b err_count=%0d expected 513/1/0", edges, pass, err_count);
        end
    endtask

    initial begin
        test_reset();
        test_clean_pass();
        test_inject("inj_last", 9'h1FF);
        test_inject("inj_first", 9'h000);
        test_restart_after_fail();
        test_held_start();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
